// File: rtl/rom_arbiter.sv
// rom_arbiter: shares the boot ROM port between instruction fetch (m0) and data load (m1).
// Ports: Hclock, Hreset (synchronous, active-low);
//        m0_/m1_ req/addr/write in, gnt/rvalid/rdata/err out;
//        rom_select/rom_ready/rom_address/rom_write out, rom_readdata/rom_hready/rom_hresponse in.
// Build option ROM_ARB_ROUND_ROBIN_EN: round-robin tie-break; otherwise m0 has fixed priority.
module rom_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              Hclock,
    input  logic              Hreset,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic              m0_write,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic              m1_write,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic              rom_select,
    output logic              rom_ready,
    output logic [ADDR_W-1:0] rom_address,
    output logic              rom_write,
    input  logic [DATA_W-1:0] rom_readdata,
    input  logic              rom_hready,
    input  logic              rom_hresponse
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR} state_t;
    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              arb_en, tie_m0, legal, resp, err, win_write;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] rdata;
`ifdef ROM_ARB_ROUND_ROBIN_EN
    // last_q = 1 means m1 was granted last, so m0 wins the next tie
    logic last_q, last_d;
    always_comb tie_m0 = last_q;
`else
    always_comb tie_m0 = 1'b1;
`endif
    always_comb begin
        // a completing DATA cycle frees the bus, so it may grant alongside the response
        arb_en    = state_q == IDLE || (state_q == DATA && rom_hready);
        m0_gnt    = arb_en && m0_req && (!m1_req || tie_m0);
        m1_gnt    = arb_en && m1_req && !m0_gnt;
        win_addr  = m1_gnt ? m1_addr : m0_addr;
        win_write = m1_gnt ? m1_write : m0_write;
        legal     = !win_write && win_addr[1:0] == 2'b00;
        resp      = state_q == ERR || (state_q == DATA && rom_hready);
        err       = state_q == ERR || rom_hresponse;
        rdata     = state_q == DATA ? rom_readdata : '0;
        m0_rvalid = resp && !owner_q;
        m1_rvalid = resp && owner_q;
        m0_rdata  = m0_rvalid ? rdata : '0;
        m1_rdata  = m1_rvalid ? rdata : '0;
        m0_err    = m0_rvalid && err;
        m1_err    = m1_rvalid && err;
        owner_d   = (m0_gnt || m1_gnt) ? m1_gnt : owner_q;
        addr_d    = (m0_gnt || m1_gnt) ? win_addr : addr_q;
        state_d   = (m0_gnt || m1_gnt) ? (legal ? ADDR : ERR) :
                    state_q == ADDR ? DATA :
                    (state_q == DATA && !rom_hready) ? DATA : IDLE;
`ifdef ROM_ARB_ROUND_ROBIN_EN
        last_d    = (m0_gnt || m1_gnt) ? m1_gnt : last_q;
`endif
    end
    always_comb begin
        rom_select  = state_q == ADDR;
        rom_ready   = state_q == ADDR;
        rom_address = addr_q;
        rom_write   = 1'b0;
    end
    always_ff @(posedge Hclock) begin
        if (!Hreset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            addr_q  <= '0;
`ifdef ROM_ARB_ROUND_ROBIN_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
`ifdef ROM_ARB_ROUND_ROBIN_EN
            last_q  <= last_d;
`endif
        end
    end
endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed vector table plus randomized traffic checked against a transaction model.
module tb_rom_arbiter;
    logic Hclock = 1'b0;
    logic Hreset = 1'b0;
    logic rq [2];
    logic wr [2];
    logic [8:0] ad [2];
    logic m0_req, m1_req, m0_write, m1_write;
    logic [8:0] m0_addr, m1_addr, rom_address;
    logic m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata, rom_readdata;
    logic rom_select, rom_ready, rom_write;
    logic rom_hready = 1'b1;
    logic rom_hresponse = 1'b0;
    logic [31:0] rom_mem [128];
    logic [6:0] rom_lat = 7'd0;
    int vectors = 0;
    int errors = 0;

    assign m0_req = rq[0];
    assign m1_req = rq[1];
    assign m0_write = wr[0];
    assign m1_write = wr[1];
    assign m0_addr = ad[0];
    assign m1_addr = ad[1];

    rom_arbiter #(.ADDR_W(9), .DATA_W(32)) dut (
        .Hclock(Hclock), .Hreset(Hreset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_write(m0_write), .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_write(m1_write), .m1_gnt(m1_gnt),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .rom_select(rom_select), .rom_ready(rom_ready), .rom_address(rom_address),
        .rom_write(rom_write), .rom_readdata(rom_readdata), .rom_hready(rom_hready),
        .rom_hresponse(rom_hresponse)
    );

    always #5 Hclock = ~Hclock;

    // ROM slave model: latches the word index when selected, serves it during the data phase
    always @(posedge Hclock) if (rom_select && rom_ready) rom_lat <= rom_address[8:2];
    assign rom_readdata = rom_mem[rom_lat];

    typedef struct packed {
        logic        rn;
        logic        r0;
        logic [8:0]  a0;
        logic        w0;
        logic        r1;
        logic [8:0]  a1;
        logic        w1;
        logic        hr;
        logic        hs;
        logic [8:0]  ctrl;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [8:0]  ra;
        logic        rs;
    } vec_t;
    vec_t tbl [$];

    task automatic row(input logic rn, input logic r0, input logic [8:0] a0, input logic w0,
                       input logic r1, input logic [8:0] a1, input logic w1,
                       input logic hr, input logic hs, input logic [8:0] ctrl,
                       input logic [31:0] d0, input logic [31:0] d1, input logic [8:0] ra,
                       input logic rs);
        tbl.push_back('{rn, r0, a0, w0, r1, a1, w1, hr, hs, ctrl, d0, d1, ra, rs});
    endtask

    // ctrl bits: {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, rom_select, rom_ready, rom_write}
    function automatic logic [81:0] actual(input logic chk_ra);
        return {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err && m0_rvalid, m1_err && m1_rvalid,
                rom_select, rom_ready, rom_write, m0_rdata, m1_rdata, chk_ra ? rom_address : 9'd0};
    endfunction

    task automatic check(input string name, input logic [81:0] act, input logic [81:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    logic       has_t, t_own, t_legal, last, rv, eerr, arb, eg0, eg1, esel;
    logic       gr [2];
    int         t_age;
    logic [8:0] t_addr;
    logic [31:0] ed;

    initial begin
        for (int i = 0; i < 128; i++) rom_mem[i] = 32'hC0DE0000 | i;
        rom_mem[3] = 32'h3c10be00;
        rom_mem[4] = 32'h3c08464c;
        rom_mem[5] = 32'h3508457f;
        for (int i = 0; i < 2; i++) begin rq[i] = 0; wr[i] = 0; ad[i] = '0; gr[i] = 0; end
        // reset state, single read, back-to-back reads
        row(1, 0,9'h000,0, 0,9'h000,0, 1,0, 9'b000000000, 0, 0, 9'h000, 1);
        row(1, 1,9'h00C,0, 0,9'h000,0, 1,0, 9'b100000000, 0, 0, 0, 0);
        row(1, 0,9'h000,0, 0,9'h000,0, 1,0, 9'b000000110, 0, 0, 9'h00C, 0);
        row(1, 0,9'h000,0, 0,9'h000,0, 1,0, 9'b001000000, 32'h3c10be00, 0, 0, 0);
        row(1, 0,9'h000,0, 0,9'h000,0, 1,0, 9'b000000000, 0, 0, 0, 0);
        row(1, 0,9'h000,0, 1,9'h010,0, 1,0, 9'b010000000, 0, 0, 0, 0);
        row(1, 0,9'h000,0, 1,9'h014,0, 1,0, 9'b000000110, 0, 0, 9'h010, 0);
        row(1, 0,9'h000,0, 1,9'h014,0, 1,0, 9'b010100000, 0, 32'h3c08464c, 0, 0);
        row(1, 0,9'h000,0, 0,9'h000,0, 1,0, 9'b000000110, 0, 0, 9'h014, 0);
        row(1, 0,9'h000,0, 0,9'h000,0, 1,0, 9'b000100000, 0, 32'h3508457f, 0, 0);
        row(1, 0,9'h000,0, 0,9'h000,0, 1,0, 9'b000000000, 0, 0, 0, 0);
        // illegal write and misaligned read
        row(1, 0,9'h000,0, 1,9'h020,1, 1,0, 9'b010000000, 0, 0, 0, 0);
        row(1, 1,9'h021,0, 0,9'h000,0, 1,0, 9'b000101000, 0, 0, 0, 0);
        row(1, 1,9'h021,0, 0,9'h000,0, 1,0, 9'b100000000, 0, 0, 0, 0);
        row(1, 0,9'h000,0, 0,9'h000,0, 1,0, 9'b001010000, 0, 0, 0, 0);
        row(1, 0,9'h000,0, 0,9'h000,0, 1,0, 9'b000000000, 0, 0, 0, 0);
        // two wait states then an error response
        row(1, 1,9'h000,0, 0,9'h000,0, 1,0, 9'b100000000, 0, 0, 0, 0);
        row(1, 0,9'h000,0, 0,9'h000,0, 1,0, 9'b000000110, 0, 0, 9'h000, 0);
        row(1, 0,9'h000,0, 0,9'h000,0, 0,0, 9'b000000000, 0, 0, 0, 0);
        row(1, 0,9'h000,0, 0,9'h000,0, 0,0, 9'b000000000, 0, 0, 0, 0);
        row(1, 0,9'h000,0, 0,9'h000,0, 1,1, 9'b001010000, 32'hC0DE0000, 0, 0, 0);
        row(1, 0,9'h000,0, 0,9'h000,0, 1,0, 9'b000000000, 0, 0, 0, 0);
        // contention: both request continuously
`ifdef ROM_ARB_ROUND_ROBIN_EN
        row(1, 1,9'h008,0, 1,9'h004,0, 1,0, 9'b010000000, 0, 0, 0, 0);
        row(1, 1,9'h008,0, 1,9'h004,0, 1,0, 9'b000000110, 0, 0, 9'h004, 0);
        row(1, 1,9'h008,0, 1,9'h004,0, 1,0, 9'b100100000, 0, 32'hC0DE0001, 0, 0);
        row(1, 1,9'h008,0, 1,9'h004,0, 1,0, 9'b000000110, 0, 0, 9'h008, 0);
        row(1, 1,9'h008,0, 1,9'h004,0, 1,0, 9'b011000000, 32'hC0DE0002, 0, 0, 0);
        row(1, 0,9'h000,0, 0,9'h000,0, 1,0, 9'b000000110, 0, 0, 9'h004, 0);
        row(1, 0,9'h000,0, 0,9'h000,0, 1,0, 9'b000100000, 0, 32'hC0DE0001, 0, 0);
`else
        row(1, 1,9'h008,0, 1,9'h004,0, 1,0, 9'b100000000, 0, 0, 0, 0);
        row(1, 1,9'h008,0, 1,9'h004,0, 1,0, 9'b000000110, 0, 0, 9'h008, 0);
        row(1, 1,9'h008,0, 1,9'h004,0, 1,0, 9'b101000000, 32'hC0DE0002, 0, 0, 0);
        row(1, 1,9'h008,0, 1,9'h004,0, 1,0, 9'b000000110, 0, 0, 9'h008, 0);
        row(1, 1,9'h008,0, 1,9'h004,0, 1,0, 9'b101000000, 32'hC0DE0002, 0, 0, 0);
        row(1, 0,9'h000,0, 0,9'h000,0, 1,0, 9'b000000110, 0, 0, 9'h008, 0);
        row(1, 0,9'h000,0, 0,9'h000,0, 1,0, 9'b001000000, 32'hC0DE0002, 0, 0, 0);
`endif
        // reset during the address phase aborts the read
        row(1, 1,9'h00C,0, 0,9'h000,0, 1,0, 9'b100000000, 0, 0, 0, 0);
        row(0, 0,9'h000,0, 0,9'h000,0, 1,0, 9'b000000110, 0, 0, 9'h00C, 0);
        row(1, 0,9'h000,0, 0,9'h000,0, 1,0, 9'b000000000, 0, 0, 9'h000, 1);
        row(1, 0,9'h000,0, 0,9'h000,0, 1,0, 9'b000000000, 0, 0, 9'h000, 1);
        row(1, 0,9'h000,0, 0,9'h000,0, 1,0, 9'b000000000, 0, 0, 9'h000, 1);

        repeat (2) @(posedge Hclock);
        #1;
        Hreset = 1;
        for (int i = 0; i < tbl.size(); i++) begin
            Hreset = tbl[i].rn;
            rq[0] = tbl[i].r0; ad[0] = tbl[i].a0; wr[0] = tbl[i].w0;
            rq[1] = tbl[i].r1; ad[1] = tbl[i].a1; wr[1] = tbl[i].w1;
            rom_hready = tbl[i].hr; rom_hresponse = tbl[i].hs;
            #2;
            check($sformatf("row%0d", i), actual(tbl[i].ctrl[2] || tbl[i].rs),
                  {tbl[i].ctrl, tbl[i].d0, tbl[i].d1, (tbl[i].ctrl[2] || tbl[i].rs) ? tbl[i].ra : 9'd0});
            @(posedge Hclock);
            #1;
        end

        // randomized traffic against a transaction-level model
        Hreset = 0;
        for (int i = 0; i < 2; i++) rq[i] = 0;
        @(posedge Hclock);
        #1;
        Hreset = 1;
        has_t = 0; t_own = 0; t_legal = 0; t_age = 0; t_addr = '0; last = 1;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (gr[i]) rq[i] = 0;
                if (rq[i] && $urandom_range(0, 39) == 0) rq[i] = 0;
                else if (!rq[i] && $urandom_range(0, 9) < 4) begin
                    rq[i] = 1;
                    ad[i] = 9'($urandom);
                    if ($urandom_range(0, 3) != 0) ad[i][1:0] = 2'b00;
                    wr[i] = $urandom_range(0, 9) == 0;
                end
            end
            rom_hready = $urandom_range(0, 3) != 0;
            rom_hresponse = $urandom_range(0, 4) == 0;
            #2;
            rv = 0; eerr = 0; ed = '0;
            if (has_t && !t_legal && t_age == 1) begin rv = 1; eerr = 1; end
            else if (has_t && t_legal && t_age >= 2 && rom_hready) begin
                rv = 1; eerr = rom_hresponse; ed = rom_mem[t_addr[8:2]];
            end
            arb = !has_t || (rv && t_legal);
`ifdef ROM_ARB_ROUND_ROBIN_EN
            eg0 = arb && rq[0] && (!rq[1] || last);
`else
            eg0 = arb && rq[0];
`endif
            eg1 = arb && rq[1] && !eg0;
            esel = has_t && t_legal && t_age == 1;
            check($sformatf("rand%0d", c), actual(esel),
                  {eg0, eg1, rv && !t_own, rv && t_own, eerr && rv && !t_own, eerr && rv && t_own,
                   esel, esel, 1'b0, t_own ? 32'd0 : ed, t_own ? ed : 32'd0, esel ? t_addr : 9'd0});
            if (rv) has_t = 0;
            else if (has_t) t_age++;
            gr[0] = eg0; gr[1] = eg1;
            if (eg0 || eg1) begin
                has_t = 1; t_own = eg1; t_age = 1; last = eg1;
                t_addr = ad[eg1 ? 1 : 0];
                t_legal = !wr[eg1 ? 1 : 0] && t_addr[1:0] == 2'b00;
            end
            @(posedge Hclock);
            #1;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Two-port arbiter and sequencer for the 128-word boot ROM slave. It shares the single ROM port between the instruction-fetch requester (m0) and the data-load requester (m1). It drives the ROM's select/ready/address handshake, returns read data to the granted requester, and rejects illegal writes and misaligned accesses locally. It sits between the CPU memory stage and the ROM slave on the boot bus.

## Interface
- ADDR_W, 9: byte-address width of the ROM window
- DATA_W, 32: read-data width
- Hclock  in  1  clock, all logic on rising edge
- Hreset  in  1  reset, synchronous, active-low
- m0_req, m1_req  in  1  access request; held high until the matching gnt pulse
- m0_addr, m1_addr  in  ADDR_W  byte address; sampled in the gnt cycle
- m0_write, m1_write  in  1  write request flag (illegal, rejected)
- m0_gnt, m1_gnt  out  1  one-cycle grant pulse; address is captured in that cycle
- m0_rvalid, m1_rvalid  out  1  one-cycle response pulse
- m0_rdata, m1_rdata  out  DATA_W  read data; valid when rvalid is high, 0 otherwise
- m0_err, m1_err  out  1  error flag; valid when rvalid is high
- rom_select  out  1  ROM Hselect
- rom_ready  out  1  ROM ready (address-latch enable)
- rom_address  out  ADDR_W  ROM Haddress
- rom_write  out  1  ROM Hwrite; constantly 0
- rom_readdata  in  DATA_W  ROM Hreaddata
- rom_hready  in  1  ROM Hready
- rom_hresponse  in  1  ROM Hresponse (1 = error)

## Operation
- States: IDLE, ADDR, DATA, ERR.
- **Arbitration** is performed in IDLE, and in DATA when the current response completes.
  - One winner is chosen.
  - Its gnt pulses.
  - Its addr and write flag are latched together with the owner id.
- **Routing of the winner:**
  - Legal access (write=0 and addr[1:0]=0) → ADDR.
  - Otherwise → ERR.
- **ADDR:**
  - rom_select=1, rom_ready=1, rom_address=latched addr.
  - The ROM registers the address at the end of this cycle.
  - Next state: DATA.
- **DATA:**
  - rom_select=0, rom_ready=0.
  - If rom_hready=1: owner rvalid=1, rdata=rom_readdata, err=rom_hresponse. Then go to ADDR/ERR if a new request is granted this cycle, else IDLE.
  - If rom_hready=0: remain in DATA and hold the owner.
- **ERR:**
  - The ROM is not touched.
  - Owner rvalid=1, err=1, rdata=0.
  - Next state: IDLE.
- Non-owner rvalid/err/rdata are 0 in every state.
- A gnt is never issued to a requester whose req is low.
- At most one gnt per cycle.
- The address is truncated to ADDR_W; word index = addr[8:2].

## Timing
- **Reset values:** state=IDLE, all gnt/rvalid/err=0, rdata=0, rom_select=0, rom_ready=0, rom_address=0, rom_write=0, round-robin pointer favours m0.
- **Read latency:** gnt in cycle N, ROM address phase in N+1, rvalid in N+2 when rom_hready=1.
- **Throughput:** back-to-back reads, one every 2 cycles (DATA overlaps the next grant).
- **Error latency:** gnt in N, rvalid+err in N+1.
- **rvalid/rdata/err:** combinational from state and ROM inputs. gnt is combinational from state and req. rom_* outputs are decoded from registered state/address only.
- **Simultaneous m0_req and m1_req:** resolved per Configuration.
- **Reset asserted mid-transaction:** the transaction is aborted; no rvalid is issued for it; the requester must re-request.
- **req dropped before gnt:** no grant, no side effects.

## Configuration
- Macro: ROM_ARB_ROUND_ROBIN_EN.
- **Defined:** round-robin arbitration.
  - On a tie, the requester not granted last wins.
  - The pointer updates on every gnt.
- **Undefined:** fixed priority; m0 always wins a tie. The pointer logic is absent.

## Test plan
- **Single read:** m0 reads addr 0x00C with ROM word 3 = 0x3c10be00 → m0_gnt at N, rom_select=1 with rom_address=0x00C at N+1, m0_rvalid=1 with m0_rdata=0x3c10be00 and err=0 at N+2.
- **Back-to-back reads:** m1 holds req for addrs 0x010 then 0x014 → rvalid at N+2 and N+4 with data 0x3c08464c then 0x3508457f; rom_select high only in N+1 and N+3.
- **Contention:** m0 and m1 both request continuously.
  - Macro defined: grants alternate m0, m1, m0, m1.
  - Macro undefined: all grants go to m0 and m1 is starved.
- **Illegal access:** m1 write to 0x020 and m0 read to 0x021 → each rvalid at gnt+1 with err=1 and rdata=0; rom_select stays 0.
- **Wait state and error:** rom_hready held 0 for 2 cycles in DATA, then rom_hresponse=1 → rvalid is delayed 2 cycles and err=1.
- **Reset mid-op:** Hreset=0 during ADDR → next cycle state=IDLE, all outputs at reset values, no rvalid ever for that request.
